byte_striping_nlane: RTL and testbench

//  Parametrised successor to the 2-lane byte striper. Takes one word per clk_2f cycle and

---
 rtl/byte_striping_nlane.sv | 122 ++++++++++++
 tb/tb_byte_striping_nlane.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_striping_nlane.sv
// Purpose : round-robin word striper, one input word per clk_2f cycle spread over NUM_LANES lanes.
// Latency : 1 cycle from accepted valid_in/data_in to lane_valid/lane_data/group_done.
// Backpres: none; every valid word is accepted, there is no ready path back to the source.
//
// Ports:
//   clk_2f       word clock, all state on rising edge
//   reset        synchronous, active-high
//   valid_in     qualifies data_in
//   data_in      DATA_WIDTH input word
//   lane_valid   one-hot pulse, bit k = lane k written this cycle
//   lane_data    lane k at [k*DATA_WIDTH +: DATA_WIDTH], holds when not written
//   group_done   pulses together with the write to lane NUM_LANES-1
//   group_abort  pulses when a partial group is dropped by realignment on idle
//   lane_parity  (only with BYTE_STRIPING_PARITY_EN) XOR-reduce of each lane word
//
// Optional feature macro: BYTE_STRIPING_PARITY_EN adds the lane_parity output.

module byte_striping_nlane #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_LANES     = 4,
    parameter int PTR_W         = 2,
    parameter int ALIGN_ON_IDLE = 1
) (
    input  logic                            clk_2f,
    input  logic                            reset,
    input  logic                            valid_in,
    input  logic [DATA_WIDTH-1:0]           data_in,
    output logic [NUM_LANES-1:0]            lane_valid,
    output logic [NUM_LANES*DATA_WIDTH-1:0] lane_data,
`ifdef BYTE_STRIPING_PARITY_EN
    output logic [NUM_LANES-1:0]            lane_parity,
`endif
    output logic                            group_done,
    output logic                            group_abort
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STRIPE = 1'b1;

    // Index of the last lane; the pointer wraps explicitly on this value so
    // non-power-of-two lane counts never rely on pointer overflow.
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_LANES - 1);

    logic [0:0]                      state_q, state_d;
    logic [PTR_W-1:0]                ptr_q, ptr_d;
    logic [NUM_LANES-1:0]            lane_valid_q, lane_valid_d;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_data_q, lane_data_d;
    logic                            done_q, done_d;
    logic                            abort_q, abort_d;
`ifdef BYTE_STRIPING_PARITY_EN
    logic [NUM_LANES-1:0]            parity_q, parity_d;
`endif

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        lane_valid_d = '0;
        lane_data_d  = lane_data_q;
        done_d       = 1'b0;
        abort_d      = 1'b0;
`ifdef BYTE_STRIPING_PARITY_EN
        parity_d     = parity_q;
`endif

        if (valid_in) begin
            // Accepting a word is identical from IDLE and STRIPE.
            state_d = S_STRIPE;
            for (int k = 0; k < NUM_LANES; k++) begin
                if (ptr_q == PTR_W'(k)) begin
                    lane_valid_d[k]                          = 1'b1;
                    lane_data_d[k*DATA_WIDTH +: DATA_WIDTH]  = data_in;
`ifdef BYTE_STRIPING_PARITY_EN
                    parity_d[k]                              = ^data_in;
`endif
                end
            end
            done_d = (ptr_q == LAST_LANE);
            ptr_d  = (ptr_q == LAST_LANE) ? '0 : ptr_q + PTR_W'(1);
        end else if (state_q == S_STRIPE) begin
            // First idle cycle after a burst: optionally realign to lane 0 and
            // flag that the lanes already written form an incomplete group.
            state_d = S_IDLE;
            if (ALIGN_ON_IDLE != 0) begin
                ptr_d   = '0;
                abort_d = (ptr_q != '0);
            end
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            lane_valid_q <= '0;
            lane_data_q  <= '0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
`ifdef BYTE_STRIPING_PARITY_EN
            parity_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            lane_valid_q <= lane_valid_d;
            lane_data_q  <= lane_data_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
`ifdef BYTE_STRIPING_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign lane_valid  = lane_valid_q;
    assign lane_data   = lane_data_q;
    assign group_done  = done_q;
    assign group_abort = abort_q;
`ifdef BYTE_STRIPING_PARITY_EN
    assign lane_parity = parity_q;
`endif

endmodule

// File: tb/tb_byte_striping_nlane.sv
// Purpose : self-checking bench for byte_striping_nlane; four configurations share one stimulus.
// Latency : model predicts outputs one edge after the inputs are applied.
// Backpres: none in the design; the bench drives a word whenever it chooses.

module tb_byte_striping_nlane;

    logic        clk_2f = 1'b0;
    logic        reset  = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;

    always #5 clk_2f = ~clk_2f;

    // Instance 0: 4 lanes, realign. 1: 4 lanes, hold. 2: 3 lanes, realign. 3: 1 lane.
    logic [3:0]   lv0, lv1;
    logic [2:0]   lv2;
    logic [0:0]   lv3;
    logic [127:0] ld0, ld1;
    logic [95:0]  ld2;
    logic [31:0]  ld3;
    logic         gd0, gd1, gd2, gd3;
    logic         ga0, ga1, ga2, ga3;
`ifdef BYTE_STRIPING_PARITY_EN
    logic [3:0]   pr0, pr1;
    logic [2:0]   pr2;
    logic [0:0]   pr3;
`endif

    byte_striping_nlane #(.DATA_WIDTH(32), .NUM_LANES(4), .PTR_W(2), .ALIGN_ON_IDLE(1)) dut0 (
        .clk_2f(clk_2f), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .lane_valid(lv0), .lane_data(ld0),
`ifdef BYTE_STRIPING_PARITY_EN
        .lane_parity(pr0),
`endif
        .group_done(gd0), .group_abort(ga0));

    byte_striping_nlane #(.DATA_WIDTH(32), .NUM_LANES(4), .PTR_W(2), .ALIGN_ON_IDLE(0)) dut1 (
        .clk_2f(clk_2f), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .lane_valid(lv1), .lane_data(ld1),
`ifdef BYTE_STRIPING_PARITY_EN
        .lane_parity(pr1),
`endif
        .group_done(gd1), .group_abort(ga1));

    byte_striping_nlane #(.DATA_WIDTH(32), .NUM_LANES(3), .PTR_W(2), .ALIGN_ON_IDLE(1)) dut2 (
        .clk_2f(clk_2f), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .lane_valid(lv2), .lane_data(ld2),
`ifdef BYTE_STRIPING_PARITY_EN
        .lane_parity(pr2),
`endif
        .group_done(gd2), .group_abort(ga2));

    byte_striping_nlane #(.DATA_WIDTH(32), .NUM_LANES(1), .PTR_W(1), .ALIGN_ON_IDLE(1)) dut3 (
        .clk_2f(clk_2f), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .lane_valid(lv3), .lane_data(ld3),
`ifdef BYTE_STRIPING_PARITY_EN
        .lane_parity(pr3),
`endif
        .group_done(gd3), .group_abort(ga3));

    // Reference model: each configuration tracks how many words of the current
    // group it has seen and whether the previous cycle carried a word.
    int          nl[4] = '{4, 4, 3, 1};
    int          al[4] = '{1, 0, 1, 1};
    int          pos[4];
    bit          busy[4];
    logic [3:0]  elv[4];
    logic        edone[4];
    logic        eabort[4];
    logic [31:0] edata[4][4];
    logic [3:0]  epar[4];

    int ncmp  = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack_data(input int i);
        logic [127:0] v = '0;
        for (int k = 0; k < nl[i]; k++) v[k*32 +: 32] = edata[i][k];
        return v;
    endfunction

    task automatic model(input logic r, input logic v, input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                pos[i] = 0; busy[i] = 0; elv[i] = '0; edone[i] = 0; eabort[i] = 0; epar[i] = '0;
                for (int k = 0; k < 4; k++) edata[i][k] = '0;
            end else if (v) begin
                elv[i]         = 4'(1 << pos[i]);
                edata[i][pos[i]] = d;
                epar[i][pos[i]]  = ^d;
                edone[i]       = (pos[i] == nl[i] - 1);
                eabort[i]      = 0;
                pos[i]         = (pos[i] + 1) % nl[i];
                busy[i]        = 1;
            end else begin
                elv[i]    = '0;
                edone[i]  = 0;
                eabort[i] = busy[i] && (al[i] != 0) && (pos[i] != 0);
                if (busy[i] && al[i] != 0) pos[i] = 0;
                busy[i] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " i0 valid"}, 128'(lv0), 128'(elv[0]));
        chk({tag, " i0 data"},  128'(ld0), pack_data(0));
        chk({tag, " i0 done"},  128'(gd0), 128'(edone[0]));
        chk({tag, " i0 abort"}, 128'(ga0), 128'(eabort[0]));
        chk({tag, " i1 valid"}, 128'(lv1), 128'(elv[1]));
        chk({tag, " i1 data"},  128'(ld1), pack_data(1));
        chk({tag, " i1 done"},  128'(gd1), 128'(edone[1]));
        chk({tag, " i1 abort"}, 128'(ga1), 128'(eabort[1]));
        chk({tag, " i2 valid"}, 128'(lv2), 128'(elv[2]));
        chk({tag, " i2 data"},  128'(ld2), pack_data(2));
        chk({tag, " i2 done"},  128'(gd2), 128'(edone[2]));
        chk({tag, " i2 abort"}, 128'(ga2), 128'(eabort[2]));
        chk({tag, " i3 valid"}, 128'(lv3), 128'(elv[3]));
        chk({tag, " i3 data"},  128'(ld3), pack_data(3));
        chk({tag, " i3 done"},  128'(gd3), 128'(edone[3]));
        chk({tag, " i3 abort"}, 128'(ga3), 128'(eabort[3]));
        // Structural properties that hold for every configuration.
        chk({tag, " i0 onehot"}, 128'($onehot0(lv0)), 128'(1));
        chk({tag, " i0 abort&valid"}, 128'(ga0 && (lv0 != 0)), 128'(0));
`ifdef BYTE_STRIPING_PARITY_EN
        chk({tag, " i0 parity"}, 128'(pr0), 128'(epar[0]));
        chk({tag, " i2 parity"}, 128'(pr2), 128'(epar[2][2:0]));
`endif
    endtask

    task automatic step(input string tag, input logic r, input logic v, input logic [31:0] d);
        reset    = r;
        valid_in = v;
        data_in  = d;
        @(posedge clk_2f);
        #1;
        model(r, v, d);
        check_all(tag);
    endtask

    initial begin
        // Power-on reset held for two cycles with a valid word presented.
        step("rst0", 1'b1, 1'b1, 32'hDEAD_BEEF);
        step("rst1", 1'b1, 1'b1, 32'hDEAD_BEEF);

        // Back-to-back burst A0..A7.
        for (int w = 0; w < 8; w++) step("burstA", 1'b0, 1'b1, 32'hA0 + 32'(w));
        chk("A7 on lane3", ld0[96 +: 32], 32'hA7);

        // Partial group then idle: realign vs hold.
        step("B0", 1'b0, 1'b1, 32'hB0);
        step("B1", 1'b0, 1'b1, 32'hB1);
        step("idleB", 1'b0, 1'b0, 32'h1234_5678);
        chk("abort pulse i0", 128'(ga0), 128'(1));
        chk("no abort i1", 128'(ga1), 128'(0));
        step("B2", 1'b0, 1'b1, 32'hB2);
        chk("B2 lane0 i0", 128'(lv0), 128'(4'b0001));
        chk("B2 lane2 i1", 128'(lv1), 128'(4'b0100));
        chk("lane3 kept i0", ld0[96 +: 32], 32'hA7);
        step("idle2", 1'b0, 1'b0, 32'h0);
        step("idle3", 1'b0, 1'b0, 32'hFFFF_FFFF);

        // Fresh groups of six words, mainly for the 3-lane instance.
        step("rstC", 1'b1, 1'b0, 32'h0);
        for (int w = 0; w < 6; w++) step("burstC", 1'b0, 1'b1, 32'hC0 + 32'(w));

        // Reset in the middle of a group.
        step("rstD", 1'b1, 1'b0, 32'h0);
        step("D0", 1'b0, 1'b1, 32'hD0);
        step("D1", 1'b0, 1'b1, 32'hD1);
        step("rstmid", 1'b1, 1'b1, 32'hD2);
        chk("rstmid no abort", 128'(ga0), 128'(0));
        step("after rst", 1'b0, 1'b1, 32'h0000_0001);
        chk("after rst lane0", 128'(lv0), 128'(4'b0001));
        step("par3", 1'b0, 1'b1, 32'h0000_0003);
        step("idleP", 1'b0, 1'b0, 32'h0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic        v;
            logic [31:0] d;
            r = ($urandom_range(0, 50) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = $urandom;
            step("rand", r, v, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
